// File: rtl/dense_layer_seq_pkg.sv
// Shared FSM state type, default word format and sizing/saturation helpers
// for the dense_layer_seq engine and its lanes.
package dense_pkg;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, WRITE, DONE} state_e;

  localparam int DEFAULT_BITSIZE = 16;
  localparam int DEFAULT_FRAC    = 8;

  // Weight ROM address width: one word per (group, input) pair, never zero bits.
  function automatic int addr_width(input int n_in, input int n_out, input int lanes);
    int depth;
    depth = ((n_out + lanes - 1) / lanes) * n_in;
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Handshake, operand and weight-ROM bundle between a layer controller (master)
// and one dense_layer_seq engine (slave).
interface dense_layer_seq_if
  import dense_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 92,
  parameter int LANES   = 4
);
  localparam int ADDR_W = addr_width(N_IN, N_OUT, LANES);

  logic                       start;
  logic [BITSIZE*N_IN-1:0]    x;
  logic [BITSIZE*N_OUT-1:0]   b;
  logic [ADDR_W-1:0]          w_addr;
  logic [BITSIZE*LANES-1:0]   w_rdata;
  logic [BITSIZE*N_OUT-1:0]   y;
  logic                       busy;
  logic                       done;
  logic                       y_valid;

  modport master (output start, x, b, w_rdata,
                  input  w_addr, y, busy, done, y_valid);
  modport slave  (input  start, x, b, w_rdata,
                  output w_addr, y, busy, done, y_valid);
endinterface

// File: rtl/dense_mac_lane.sv
// One neuron accumulator: bias preload, signed MAC, round-half-up output with
// optional ReLU. DENSE_SAT_EN selects saturation instead of wrap on narrowing.
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int FRAC    = DEFAULT_FRAC,
  parameter int ACC_W   = 40,
  parameter int RELU    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_bias,
  input  logic                      mac_en,
  input  logic signed [BITSIZE-1:0] bias,
  input  logic signed [BITSIZE-1:0] x_k,
  input  logic signed [BITSIZE-1:0] w_k,
  output logic        [BITSIZE-1:0] y_out
);
  localparam int PW = 2 * BITSIZE;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] sum;
  logic        [BITSIZE-1:0] narrow;

`ifdef DENSE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(BITSIZE));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(BITSIZE));
  logic signed [ACC_W-1:0] shifted;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    acc_d = acc_q;
    prod  = PW'(x_k) * PW'(w_k);
    if (load_bias)   acc_d = ACC_W'(bias) <<< FRAC;
    else if (mac_en) acc_d = acc_q + ACC_W'(prod);

    sum = acc_q + HALF;
`ifdef DENSE_SAT_EN
    shifted = sum >>> FRAC;
    if (shifted > SAT_HI)      narrow = SAT_HI[BITSIZE-1:0];
    else if (shifted < SAT_LO) narrow = SAT_LO[BITSIZE-1:0];
    else                       narrow = shifted[BITSIZE-1:0];
`else
    narrow = BITSIZE'(sum >>> FRAC);
`endif
    y_out = ((RELU != 0) && narrow[BITSIZE-1]) ? '0 : narrow;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer y = act(W.x + b), LANES neurons per
// group, weights from a 1-cycle synchronous ROM. DENSE_SAT_EN: saturating output.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int FRAC    = DEFAULT_FRAC,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 92,
  parameter int LANES   = 4,
  parameter int ACC_W   = 40,
  parameter int RELU    = 1
) (
  input logic              clk,
  input logic              reset,
  dense_layer_seq_if.slave bus
);
  localparam int G      = (N_OUT + LANES - 1) / LANES;
  localparam int ADDR_W = addr_width(N_IN, N_OUT, LANES);
  localparam int G_W    = (G > 1) ? $clog2(G) : 1;
  localparam int K_W    = $clog2(N_IN + 1);

  localparam logic [K_W-1:0]    K_LAST     = K_W'(N_IN);
  localparam logic [K_W-1:0]    K_ADDR_END = K_W'(N_IN - 1);
  localparam logic [G_W-1:0]    G_LAST     = G_W'(G - 1);
  localparam logic [ADDR_W-1:0] N_IN_A     = ADDR_W'(N_IN);

  state_e                   state_q, state_d;
  logic [G_W-1:0]           g_q, g_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [BITSIZE*N_IN-1:0]  x_q, x_d;
  logic [BITSIZE*N_OUT-1:0] b_q, b_d;
  logic [BITSIZE*N_OUT-1:0] y_q, y_d;
  logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     y_valid_q, y_valid_d;

  logic               load_bias, mac_en, write_en;
  logic [BITSIZE-1:0] x_k;
  logic [BITSIZE-1:0] lane_bias [LANES];
  logic [BITSIZE-1:0] lane_y    [LANES];

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    k_d       = k_q;
    x_d       = x_q;
    b_d       = b_q;
    w_addr_d  = w_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    y_valid_d = y_valid_q;
    load_bias = 1'b0;
    mac_en    = 1'b0;
    write_en  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        x_d       = bus.x;
        b_d       = bus.b;
        y_valid_d = 1'b0;
        busy_d    = 1'b1;
        g_d       = '0;
        state_d   = BIAS;
      end
      // First address goes out here so ROM data lines up with MAC cycle 1.
      BIAS: begin
        load_bias = 1'b1;
        k_d       = '0;
        w_addr_d  = ADDR_W'(g_q) * N_IN_A;
        state_d   = MAC;
      end
      MAC: begin
        mac_en = (k_q != '0);
        k_d    = k_q + 1'b1;
        if (k_q < K_ADDR_END) w_addr_d = w_addr_q + 1'b1;
        if (k_q == K_LAST)    state_d  = WRITE;
      end
      WRITE: begin
        write_en = 1'b1;
        if (g_q == G_LAST) state_d = DONE;
        else begin
          g_d     = g_q + 1'b1;
          state_d = BIAS;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        y_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand muxes; neurons past N_OUT have no slot, so spare lanes never write.
  always_comb begin
    x_k = '0;
    for (int i = 0; i < N_IN; i++)
      if (k_q == K_W'(i + 1)) x_k = x_q[i*BITSIZE +: BITSIZE];
    for (int l = 0; l < LANES; l++) lane_bias[l] = '0;
    y_d = y_q;
    for (int n = 0; n < N_OUT; n++) begin
      if (g_q == G_W'(n / LANES)) begin
        lane_bias[n % LANES] = b_q[n*BITSIZE +: BITSIZE];
        if (write_en) y_d[n*BITSIZE +: BITSIZE] = lane_y[n % LANES];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      k_q       <= '0;
      x_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      k_q       <= k_d;
      x_q       <= x_d;
      b_q       <= b_d;
      y_q       <= y_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      y_valid_q <= y_valid_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(
      .BITSIZE(BITSIZE), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(RELU)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load_bias(load_bias),
      .mac_en   (mac_en),
      .bias     (lane_bias[l]),
      .x_k      (x_k),
      .w_k      (bus.w_rdata[l*BITSIZE +: BITSIZE]),
      .y_out    (lane_y[l])
    );
  end

  assign bus.w_addr  = w_addr_q;
  assign bus.y       = y_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: ReLU/linear default-size engines plus a
// small N_OUT=5, N_IN=3 engine with a per-neuron weight ROM.
module tb_dense_layer_seq;
  localparam int BW   = 16;
  localparam int NI   = 10;
  localparam int NO   = 92;
  localparam int LN   = 4;
  localparam int NI_B = 3;
  localparam int NO_B = 5;

`ifdef DENSE_SAT_EN
  localparam logic [15:0] EXP_BIG = 16'h7FFF;
`else
  localparam logic [15:0] EXP_BIG = 16'h75FF;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [15:0] x_val, b_val, w_val;
  logic        start_ac, start_b;
  int          da, nd, db, ndb;
  logic        bm, yv;

  dense_layer_seq_if #(.BITSIZE(BW), .N_IN(NI), .N_OUT(NO), .LANES(LN)) bus_a ();
  dense_layer_seq_if #(.BITSIZE(BW), .N_IN(NI), .N_OUT(NO), .LANES(LN)) bus_c ();
  dense_layer_seq_if #(.BITSIZE(BW), .N_IN(NI_B), .N_OUT(NO_B), .LANES(LN)) bus_b ();

  dense_layer_seq #(.BITSIZE(BW), .FRAC(8), .N_IN(NI), .N_OUT(NO), .LANES(LN),
                    .ACC_W(40), .RELU(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dense_layer_seq #(.BITSIZE(BW), .FRAC(8), .N_IN(NI), .N_OUT(NO), .LANES(LN),
                    .ACC_W(40), .RELU(0)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));
  dense_layer_seq #(.BITSIZE(BW), .FRAC(8), .N_IN(NI_B), .N_OUT(NO_B), .LANES(LN),
                    .ACC_W(40), .RELU(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.start = start_ac;
  assign bus_c.start = start_ac;
  assign bus_a.x     = {NI{x_val}};
  assign bus_c.x     = {NI{x_val}};
  assign bus_a.b     = {NO{b_val}};
  assign bus_c.b     = {NO{b_val}};

  // Small engine: x = {1.0, 2.0, -0.5}, biases {0.5, -1.0, 0, 0, 0}.
  assign bus_b.start = start_b;
  assign bus_b.x     = {16'hFF80, 16'h0200, 16'h0100};
  assign bus_b.b     = {16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h0080};

  function automatic logic [15:0] wb(input int n, input int k);
    case (n)
      0:       return (k == 0) ? 16'h0100 : 16'h0000;
      1:       return (k == 1) ? 16'h0080 : 16'h0000;
      2:       return 16'h0100;
      3:       return (k == 0) ? 16'hFF00 : 16'h0000;
      4:       return 16'h0001;
      default: return 16'h0100;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    bus_a.w_rdata <= {LN{w_val}};
    bus_c.w_rdata <= {LN{w_val}};
    for (int l = 0; l < LN; l++)
      bus_b.w_rdata[l*16 +: 16] <= wb((int'(bus_b.w_addr) / NI_B) * LN + l,
                                      int'(bus_b.w_addr) % NI_B);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag, input logic [NO*BW-1:0] yvec, input logic [15:0] exp);
    logic [15:0] got;
    int          idx;
    got = exp;
    idx = -1;
    for (int i = 0; i < NO; i++)
      if (yvec[i*16 +: 16] !== exp && idx < 0) begin
        idx = i;
        got = yvec[i*16 +: 16];
      end
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, got, exp);
    end
  endtask

  // Start edge is cycle 0; observation n is 1 time unit after edge n.
  task automatic run_ac(input int restart_at, input int xchg_at, output int done_at,
                        output int n_done, output logic busy_mid, output logic yv_mid);
    done_at  = -1;
    n_done   = 0;
    busy_mid = 1'b0;
    yv_mid   = 1'b1;
    start_ac = 1'b1;
    tick;
    start_ac = 1'b0;
    for (int n = 1; n <= 320; n++) begin
      tick;
      if (bus_a.done) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
      if (n == 1)              yv_mid   = bus_a.y_valid;
      if (n == 150)            busy_mid = bus_a.busy;
      if (n == restart_at)     start_ac = 1'b1;
      if (n == restart_at + 1) start_ac = 1'b0;
      if (n == xchg_at)        x_val    = 16'h0000;
    end
  endtask

  initial begin
    reset = 1'b0; start_ac = 1'b0; start_b = 1'b0;
    x_val = '0; b_val = '0; w_val = '0;
    tick; tick;
    check_y("rst_y", bus_a.y, 16'h0000);
    check("rst_w_addr", bus_a.w_addr, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_y_valid", bus_a.y_valid, 0);
    reset = 1'b1;
    tick;

    // 10 * (1.0 * 0.5) = 5.0
    x_val = 16'h0100; w_val = 16'h0080; b_val = 16'h0000;
    run_ac(-1, -1, da, nd, bm, yv);
    check("t1_done_cycle", da, 300);
    check("t1_done_count", nd, 1);
    check("t1_busy_mid", bm, 1);
    check("t1_busy_end", bus_a.busy, 0);
    check("t1_y_valid", bus_a.y_valid, 1);
    check("t1_w_addr_hold", bus_a.w_addr, 229);
    check_y("t1_y_relu", bus_a.y, 16'h0500);
    check_y("t1_y_lin", bus_c.y, 16'h0500);

    // 10 * (1.0 * -1.0) = -10.0
    w_val = 16'hFF00;
    run_ac(-1, -1, da, nd, bm, yv);
    check("t2_y_valid_cleared", yv, 0);
    check("t2_done_cycle", da, 300);
    check_y("t2_y_relu", bus_a.y, 16'h0000);
    check_y("t2_y_lin", bus_c.y, 16'hF600);

    x_val = 16'h7FFF; w_val = 16'h7FFF; b_val = 16'h7FFF;
    run_ac(-1, -1, da, nd, bm, yv);
    check_y("t3_y_relu", bus_a.y, EXP_BIG);
    check_y("t3_y_lin", bus_c.y, EXP_BIG);

    // Restart during MAC and x change after capture must not disturb the run.
    x_val = 16'h0100; w_val = 16'h0080; b_val = 16'h0000;
    run_ac(50, 2, da, nd, bm, yv);
    check("t4_done_cycle", da, 300);
    check("t4_done_count", nd, 1);
    check_y("t4_y", bus_a.y, 16'h0500);
    x_val = 16'h0100;

    start_ac = 1'b1;
    tick;
    start_ac = 1'b0;
    repeat (100) tick;
    reset = 1'b0;
    #1;
    check_y("t5_rst_y", bus_a.y, 16'h0000);
    check("t5_rst_busy", bus_a.busy, 0);
    check("t5_rst_y_valid", bus_a.y_valid, 0);
    tick;
    reset = 1'b1;
    nd = 0;
    for (int n = 0; n < 320; n++) begin
      tick;
      if (bus_a.done) nd++;
    end
    check("t5_no_done", nd, 0);
    run_ac(-1, -1, da, nd, bm, yv);
    check("t5_rerun_done_cycle", da, 300);
    check_y("t5_rerun_y", bus_a.y, 16'h0500);

    // Small engine; a start presented while in DONE must be ignored.
    db = -1; ndb = 0;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 13) start_b = 1'b1;
      tick;
      if (n == 13) start_b = 1'b0;
      if (bus_b.done) begin
        ndb++;
        if (db < 0) db = n;
      end
    end
    check("b_done_cycle", db, 13);
    check("b_done_count", ndb, 1);
    check("b_busy_end", bus_b.busy, 0);
    check("b_y_valid", bus_b.y_valid, 1);
    check("b_w_addr_hold", bus_b.w_addr, 5);
    check("b_y0", bus_b.y[0*16 +: 16], 16'h0180);
    check("b_y1", bus_b.y[1*16 +: 16], 16'h0000);
    check("b_y2", bus_b.y[2*16 +: 16], 16'h0280);
    check("b_y3", bus_b.y[3*16 +: 16], 16'hFF00);
    check("b_y4", bus_b.y[4*16 +: 16], 16'h0003);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
